// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Top-level layer FSM for one inference frame. It walks the State bus through
// CONV1_1 .. AVG_POOL3, FC_STATE and JUDGE. The State bus drives both the
// conv/pool/FC clock mux and the layer engine selection.
//
// Each layer state runs three sub-phases:
//   SETTLE - State is held steady so the downstream clock switch can settle.
//   START  - layer_start is high for exactly one cycle.
//   WAIT   - wait for the done pulse of the engine selected by State.
// A per-layer watchdog aborts the frame when a done never arrives.
//
// Ports
//   clk, rst        sole clock, synchronous active-high reset
//   frame_start     level request for a frame; only sampled in IDLE
//   PS_BRAM_busy    input BRAM still being written; blocks frame acceptance
//   abort           synchronous abort back to IDLE
//   conv_done       1-cycle done from the conv engine
//   Avg_done        1-cycle done from the average-pool engine
//   fc_done         1-cycle done from the FC engine
//   judge_done      1-cycle done from the judge logic
//   judge_result    detection result, valid together with judge_done
//   State           current layer state (registered)
//   layer_start     1-cycle start pulse for the engine selected by State
//   busy            high in every state except RESET / IDLE
//   frame_done      1-cycle pulse on successful frame completion
//   human_detected  result of the last completed frame
//   err_timeout     sticky watchdog flag; cleared when a new frame is accepted
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int STATE_DATAWIDTH = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter int CNT_W           = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       PS_BRAM_busy,
  input  logic                       abort,
  input  logic                       conv_done,
  input  logic                       Avg_done,
  input  logic                       fc_done,
  input  logic                       judge_done,
  input  logic                       judge_result,
  output logic [STATE_DATAWIDTH-1:0] State,
  output logic                       layer_start,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       human_detected,
  output logic                       err_timeout
);

  typedef enum logic [STATE_DATAWIDTH-1:0] {
    RESET     = STATE_DATAWIDTH'(0),
    IDLE      = STATE_DATAWIDTH'(1),
    CONV1_1   = STATE_DATAWIDTH'(2),
    CONV1_2   = STATE_DATAWIDTH'(3),
    AVG_POOL1 = STATE_DATAWIDTH'(4),
    CONV2_1   = STATE_DATAWIDTH'(5),
    CONV2_2   = STATE_DATAWIDTH'(6),
    AVG_POOL2 = STATE_DATAWIDTH'(7),
    CONV3_1   = STATE_DATAWIDTH'(8),
    CONV3_2   = STATE_DATAWIDTH'(9),
    AVG_POOL3 = STATE_DATAWIDTH'(10),
    FC_STATE  = STATE_DATAWIDTH'(11),
    JUDGE     = STATE_DATAWIDTH'(12)
  } state_t;

  typedef enum logic [1:0] {
    PH_SETTLE = 2'd0,
    PH_START  = 2'd1,
    PH_WAIT   = 2'd2
  } phase_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             start_q, start_d;
  logic             busy_q,  busy_d;
  logic             fdone_q, fdone_d;
  logic             human_q, human_d;
  logic             err_q,   err_d;

  // The done that belongs to the current layer; every other done is ignored.
  logic             done_hit;

  // Layer ordering; JUDGE wraps back to IDLE.
  function automatic state_t next_layer(input state_t s);
    state_t n;
    n = IDLE;
    case (s)
      CONV1_1:   n = CONV1_2;
      CONV1_2:   n = AVG_POOL1;
      AVG_POOL1: n = CONV2_1;
      CONV2_1:   n = CONV2_2;
      CONV2_2:   n = AVG_POOL2;
      AVG_POOL2: n = CONV3_1;
      CONV3_1:   n = CONV3_2;
      CONV3_2:   n = AVG_POOL3;
      AVG_POOL3: n = FC_STATE;
      FC_STATE:  n = JUDGE;
      default:   n = IDLE;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      phase_q <= PH_SETTLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      human_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      human_q <= human_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Done selection
  // ---------------------------------------------------------------------------
  always_comb begin
    done_hit = 1'b0;
    case (state_q)
      CONV1_1, CONV1_2,
      CONV2_1, CONV2_2,
      CONV3_1, CONV3_2:    done_hit = conv_done;
      AVG_POOL1, AVG_POOL2,
      AVG_POOL3:           done_hit = Avg_done;
      FC_STATE:            done_hit = fc_done;
      JUDGE:               done_hit = judge_done;
      default:             done_hit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic. Priority: abort > done > timeout (rst handled in
  // the register block).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    fdone_d = 1'b0;
    human_d = human_q;
    err_d   = err_q;

    if (abort) begin
      state_d = IDLE;
      phase_d = PH_SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RESET: begin
          state_d = IDLE;
        end

        IDLE: begin
          if (frame_start && !PS_BRAM_busy) begin
            state_d = CONV1_1;
            phase_d = PH_SETTLE;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end

        default: begin
          case (phase_q)
            PH_SETTLE: begin
              // Counter reaches SETTLE_LAST after State has been stable for
              // SETTLE_CYCLES cycles; the registered pulse follows on this edge.
              if (cnt_q == SETTLE_LAST) begin
                phase_d = PH_START;
                start_d = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end

            PH_START: begin
              // The start cycle already counts toward the watchdog, so the
              // timeout lands exactly TIMEOUT_CYCLES cycles after layer_start.
              phase_d = PH_WAIT;
              cnt_d   = CNT_W'(1);
            end

            PH_WAIT: begin
              if (done_hit) begin
                state_d = next_layer(state_q);
                phase_d = PH_SETTLE;
                cnt_d   = '0;
                if (state_q == JUDGE) begin
                  human_d = judge_result;
                  fdone_d = 1'b1;
                end
              end else if (cnt_q == TIMEOUT_LAST) begin
                state_d = IDLE;
                phase_d = PH_SETTLE;
                cnt_d   = '0;
                err_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end

            default: begin
              phase_d = PH_SETTLE;
              cnt_d   = '0;
            end
          endcase
        end
      endcase
    end

    // Registered from the next state so it always agrees with State.
    busy_d = (state_d != RESET) && (state_d != IDLE);
  end

  assign State          = state_q;
  assign layer_start    = start_q;
  assign busy           = busy_q;
  assign frame_done     = fdone_q;
  assign human_detected = human_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
  localparam int SW  = 4;
  localparam int SET = 4;
  localparam int TO  = 16;
  localparam int CW  = 21;

  localparam int EV_STATE = 0, EV_START = 1, EV_FDONE = 2;
  localparam int K_ACC = 0, K_EDGE = 1, K_TMO = 2, K_STALE = 3, K_ABORT = 4, K_RST = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0, PS_BRAM_busy = 1'b0, abort = 1'b0;
  logic conv_done = 1'b0, Avg_done = 1'b0, fc_done = 1'b0, judge_done = 1'b0;
  logic judge_result = 1'b0;
  logic [SW-1:0] State;
  logic layer_start, busy, frame_done, human_detected, err_timeout;

  typedef struct {
    int kind;
    int st;
    int err;
    int hd;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  last_hd = 0, err_model = 0, fixed_k = 0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  layer_sequencer #(
    .STATE_DATAWIDTH(SW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .PS_BRAM_busy(PS_BRAM_busy),
    .abort(abort), .conv_done(conv_done), .Avg_done(Avg_done), .fc_done(fc_done),
    .judge_done(judge_done), .judge_result(judge_result), .State(State),
    .layer_start(layer_start), .busy(busy), .frame_done(frame_done),
    .human_detected(human_detected), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic bail(input string what);
    checks++;
    errors++;
    $display("FAIL %s actual=no_response required=response_within_bound", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic push(input int kind, input int st, input int err, input int hd, input int gap);
    ev_t e;
    e.kind = kind; e.st = st; e.err = err; e.hd = hd; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_dones();
    conv_done = 1'b0; Avg_done = 1'b0; fc_done = 1'b0; judge_done = 1'b0;
  endtask

  // Matching done for a layer code (2..12)
  task automatic set_done(input int s);
    case (s)
      4, 7, 10: Avg_done   = 1'b1;
      11:       fc_done    = 1'b1;
      12:       judge_done = 1'b1;
      default:  conv_done  = 1'b1;
    endcase
  endtask

  // A done belonging to some other engine
  task automatic set_wrong(input int s);
    case (s)
      4, 7, 10: fc_done   = 1'b1;
      11, 12:   conv_done = 1'b1;
      default:  Avg_done  = 1'b1;
    endcase
  endtask

  task automatic wait_start();
    for (int i = 0; i < SET + 4; i++) begin
      step(); clear_dones();
      if (layer_start === 1'b1) return;
    end
    bail("wait_layer_start");
  endtask

  task automatic wait_state(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      step(); clear_dones();
      if (State === SW'(target)) return;
    end
    bail("wait_state");
  endtask

  // Reference behaviour: layers run 2..12 in order; each start comes SET cycles
  // after the State change; a matching done accepted within TO cycles of the
  // start advances, otherwise the frame ends in IDLE with err set.
  task automatic run_frame(input bit blocked, input int f_layer, input int f_kind,
                           input bit rnd_end, input int jr);
    int kind, k, res;
    if (blocked) begin
      PS_BRAM_busy = 1'b1; frame_start = 1'b1;
      repeat (20) step();
      chk("blocked_state", State, 1);
    end
    push(EV_STATE, 2, 0, last_hd, -1);
    err_model = 0;
    frame_start = 1'b1; PS_BRAM_busy = 1'b0;
    step();
    chk("accept_next_edge", State, 2);
    if (State !== SW'(2)) bail("frame_accept");
    for (int s = 2; s <= 12; s++) begin
      push(EV_START, s, 0, 0, -1);
      if (s == 2 || $urandom_range(0, 2) == 0) set_done(s);  // stale, lands in SETTLE
      wait_start();
      judge_result = 1'($urandom_range(0, 1));
      if (s == f_layer) kind = f_kind;
      else if (rnd_end && $urandom_range(0, 15) == 0) kind = int'($urandom_range(K_TMO, K_ABORT));
      else kind = ($urandom_range(0, 4) == 0) ? K_EDGE : K_ACC;
      frame_start = ((kind == K_ACC || kind == K_EDGE) && s != 12) ? 1'($urandom_range(0, 1)) : 1'b0;

      if (kind == K_TMO || kind == K_STALE) begin
        frame_start = 1'b0;
        push(EV_STATE, 1, 1, last_hd, TO);
        err_model = 1;
        if (kind == K_STALE) set_done(s);   // arrives during the start cycle
        wait_state(1, TO + 4);
        return;
      end

      if (kind == K_EDGE) k = TO - 1;
      else if (kind == K_RST) k = 2;
      else if (fixed_k > 0) k = fixed_k;
      else k = int'($urandom_range(1, TO - 2));
      for (int j = 1; j <= k; j++) begin
        step(); clear_dones();
        if (j == 1 && k >= 2 && (s == 2 || $urandom_range(0, 1) == 1)) set_wrong(s);
      end

      if (kind == K_RST) begin
        push(EV_STATE, 0, 0, 0, -1);
        rst = 1'b1; set_done(s); judge_result = 1'b1;
        step(); clear_dones();
        chk("rst_state", State, 0);
        chk("rst_layer_start", layer_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_human", human_detected, 0);
        chk("rst_err", err_timeout, 0);
        last_hd = 0; err_model = 0;
        push(EV_STATE, 1, 0, 0, -1);
        rst = 1'b0;
        step();
        chk("rst_release_idle", State, 1);
        return;
      end

      if (kind == K_ABORT) begin
        frame_start = 1'b0;
        push(EV_STATE, 1, err_model, last_hd, k + 1);
        abort = 1'b1; set_done(s);
        step(); clear_dones(); abort = 1'b0;
        chk("abort_state", State, 1);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_layer_start", layer_start, 0);
        chk("abort_human", human_detected, last_hd);
        return;
      end

      if (s == 12) begin
        res = (jr == 2) ? int'($urandom_range(0, 1)) : jr;
        push(EV_STATE, 1, err_model, res, k + 1);
        push(EV_FDONE, 1, 0, res, -1);
        last_hd = res;
        judge_result = 1'(res);
      end else begin
        push(EV_STATE, s + 1, err_model, last_hd, k + 1);
      end
      set_done(s);
      step(); clear_dones();
      if (State !== SW'((s == 12) ? 1 : s + 1)) bail("layer_advance");
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  initial begin : monitor
    logic [SW-1:0] prev;
    int cyc, chg, stc;
    ev_t e;
    prev = '0; cyc = 0; chg = 0; stc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        prev = State; chg = cyc;
      end else begin
        if (State !== prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_state_change", State, prev);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_state", EV_STATE, e.kind);
            chk("state_value", State, e.st);
            chk("state_err_timeout", err_timeout, e.err);
            chk("state_human", human_detected, e.hd);
            chk("state_busy", busy, (e.st > 1) ? 1 : 0);
            if (e.gap >= 0) chk("cycles_start_to_exit", cyc - stc, e.gap);
          end
          prev = State; chg = cyc;
        end
        if (layer_start === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_layer_start", layer_start, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_start", EV_START, e.kind);
            chk("start_state", State, e.st);
            chk("settle_cycles", cyc - chg, SET);
          end
          stc = cyc;
        end
        if (frame_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_done", frame_done, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_fdone", EV_FDONE, e.kind);
            chk("fdone_human", human_detected, e.hd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    bail("global_time_limit");
  end

  initial begin : driver
    rst = 1'b1;
    repeat (3) step();
    chk("reset_state", State, 0);
    chk("reset_layer_start", layer_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_human", human_detected, 0);
    chk("reset_err", err_timeout, 0);
    mon_en = 1'b1;
    push(EV_STATE, 1, 0, 0, -1);
    rst = 1'b0;
    step();
    chk("idle_after_reset", State, 1);

    // Clean frame behind a blocked start; dones 10 cycles after each start.
    fixed_k = 10;
    run_frame(1'b1, -1, K_ACC, 1'b0, 1);
    fixed_k = 0;
    chk("frame1_human", human_detected, 1);
    chk("frame1_state", State, 1);

    // Watchdog in CONV2_2.
    run_frame(1'b0, 6, K_TMO, 1'b0, 2);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_human_kept", human_detected, 1);

    // Abort while idle leaves the sticky error alone.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_err_kept", err_timeout, 1);
    chk("idle_abort_state", State, 1);

    // Abort coinciding with fc_done; result of the last good frame survives.
    run_frame(1'b0, 11, K_ABORT, 1'b0, 2);
    chk("abort_err_cleared_by_start", err_timeout, 0);

    // Done on exactly the timeout cycle in JUDGE.
    run_frame(1'b0, 12, K_EDGE, 1'b0, 0);
    chk("edge_err", err_timeout, 0);
    chk("edge_human", human_detected, 0);

    // Done during the start cycle is stale and leads to a timeout.
    run_frame(1'b0, 3, K_STALE, 1'b0, 2);
    chk("stale_err", err_timeout, 1);

    for (int f = 0; f < 30; f++) run_frame(1'($urandom_range(0, 3) == 0), -1, K_ACC, 1'b1, 2);

    run_frame(1'b0, -1, K_ACC, 1'b0, 1);
    run_frame(1'b0, 12, K_RST, 1'b0, 2);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
